// File: rtl/a5_frame_sequencer.sv
// A5/1 frame sequencer: key/COUNT load, majority-clocked mixing, then 228 keystream bits.
// Optional A5_STALL_EN adds ks_ready back-pressure during keystream generation.
module a5_frame_sequencer #(
  parameter int unsigned KEYLEN    = 64,
  parameter int unsigned FRAMELEN  = 22,
  parameter int unsigned MIXCYCLES = 100,
  parameter int unsigned CHUNKLEN  = 114
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [KEYLEN-1:0]   key,
  input  logic [FRAMELEN-1:0] frame,
`ifdef A5_STALL_EN
  input  logic                ks_ready,
`endif
  output logic                busy,
  output logic                ks_valid,
  output logic                ks_bit,
  output logic [7:0]          ks_index,
  output logic [CHUNKLEN-1:0] dl_ks,
  output logic [CHUNKLEN-1:0] ul_ks,
  output logic                done
);

  localparam int unsigned KeyIdxW = $clog2(KEYLEN);
  localparam int unsigned FrmIdxW = $clog2(FRAMELEN);
  localparam int unsigned ChkIdxW = $clog2(CHUNKLEN);
  localparam logic [7:0] KeyLast   = 8'(KEYLEN - 1);
  localparam logic [7:0] FrmLast   = 8'(FRAMELEN - 1);
  localparam logic [7:0] MixLast   = 8'(MIXCYCLES - 1);
  localparam logic [7:0] ChunkLen8 = 8'(CHUNKLEN);
`ifdef A5_STALL_EN
  localparam logic [7:0] GenTotal  = 8'(2 * CHUNKLEN);
`else
  localparam logic [7:0] GenLast   = 8'(2 * CHUNKLEN - 1);
`endif

  typedef enum logic [2:0] {
    StIdle, StLoadKey, StLoadFrame, StMix, StGen, StDone
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [18:0]         r1_q, r1_d, r1_sh, r1_mj;
  logic [21:0]         r2_q, r2_d, r2_sh, r2_mj;
  logic [22:0]         r3_q, r3_d, r3_sh, r3_mj;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic                bit_q, bit_d;
  logic [7:0]          idx_q, idx_d;
  logic [CHUNKLEN-1:0] dl_q, dl_d;
  logic [CHUNKLEN-1:0] ul_q, ul_d;
  logic                done_q, done_d;
  logic                in_bit, maj, ks_new, gen_step;
  logic [ChkIdxW-1:0]  chunk_idx;

  // Register datapath: plain shift (load phases) and majority-gated shift (mix/gen).
  always_comb begin
    in_bit = 1'b0;
    if (state_q == StLoadKey) begin
      in_bit = key[cnt_q[KeyIdxW-1:0]];
    end else if (state_q == StLoadFrame) begin
      in_bit = frame[cnt_q[FrmIdxW-1:0]];
    end
    r1_sh = {r1_q[17:0], r1_q[13] ^ r1_q[16] ^ r1_q[17] ^ r1_q[18] ^ in_bit};
    r2_sh = {r2_q[20:0], r2_q[20] ^ r2_q[21] ^ in_bit};
    r3_sh = {r3_q[21:0], r3_q[7] ^ r3_q[20] ^ r3_q[21] ^ r3_q[22] ^ in_bit};
    maj   = (r1_q[8] & r2_q[10]) | (r1_q[8] & r3_q[10]) | (r2_q[10] & r3_q[10]);
    r1_mj = (r1_q[8] == maj) ? r1_sh : r1_q;
    r2_mj = (r2_q[10] == maj) ? r2_sh : r2_q;
    r3_mj = (r3_q[10] == maj) ? r3_sh : r3_q;
    ks_new = r1_mj[18] ^ r2_mj[21] ^ r3_mj[22];
    chunk_idx = (cnt_q < ChunkLen8) ? cnt_q[ChkIdxW-1:0] : ChkIdxW'(cnt_q - ChunkLen8);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    r1_d     = r1_q;
    r2_d     = r2_q;
    r3_d     = r3_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    bit_d    = bit_q;
    idx_d    = idx_q;
    dl_d     = dl_q;
    ul_d     = ul_q;
    done_d   = 1'b0;
    gen_step = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoadKey;
          cnt_d   = '0;
          r1_d    = '0;
          r2_d    = '0;
          r3_d    = '0;
          dl_d    = '0;
          ul_d    = '0;
          busy_d  = 1'b1;
        end
      end
      StLoadKey: begin
        r1_d = r1_sh;
        r2_d = r2_sh;
        r3_d = r3_sh;
        if (cnt_q == KeyLast) begin
          state_d = StLoadFrame;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StLoadFrame: begin
        r1_d = r1_sh;
        r2_d = r2_sh;
        r3_d = r3_sh;
        if (cnt_q == FrmLast) begin
          state_d = StMix;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StMix: begin
        r1_d = r1_mj;
        r2_d = r2_mj;
        r3_d = r3_mj;
        if (cnt_q == MixLast) begin
          state_d = StGen;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StGen: begin
`ifdef A5_STALL_EN
        // cnt_q counts generated bits; leave only once the last one is consumed.
        if (!valid_q || ks_ready) begin
          if (cnt_q == GenTotal) begin
            state_d = StDone;
            cnt_d   = '0;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            gen_step = 1'b1;
            cnt_d    = cnt_q + 8'd1;
          end
        end
`else
        gen_step = 1'b1;
        if (cnt_q == GenLast) begin
          state_d = StDone;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase

    if (gen_step) begin
      r1_d    = r1_mj;
      r2_d    = r2_mj;
      r3_d    = r3_mj;
      bit_d   = ks_new;
      idx_d   = cnt_q;
      valid_d = 1'b1;
      if (cnt_q < ChunkLen8) begin
        dl_d[chunk_idx] = ks_new;
      end else begin
        ul_d[chunk_idx] = ks_new;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      r3_q    <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      bit_q   <= 1'b0;
      idx_q   <= '0;
      dl_q    <= '0;
      ul_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      r3_q    <= r3_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      dl_q    <= dl_d;
      ul_q    <= ul_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign ks_valid = valid_q;
  assign ks_bit   = bit_q;
  assign ks_index = idx_q;
  assign dl_ks    = dl_q;
  assign ul_ks    = ul_q;
  assign done     = done_q;

endmodule

// File: tb/tb_a5_frame_sequencer.sv
// Bench for a5_frame_sequencer: GSM reference vector, cycle accounting, restarts, reset
// and random keys against a behavioural A5/1 model.
module tb_a5_frame_sequencer;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [63:0]  key;
  logic [21:0]  frame;
`ifdef A5_STALL_EN
  logic         ks_ready;
`endif
  logic         busy;
  logic         ks_valid;
  logic         ks_bit;
  logic [7:0]   ks_index;
  logic [113:0] dl_ks;
  logic [113:0] ul_ks;
  logic         done;

  a5_frame_sequencer dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .key      (key),
    .frame    (frame),
`ifdef A5_STALL_EN
    .ks_ready (ks_ready),
`endif
    .busy     (busy),
    .ks_valid (ks_valid),
    .ks_bit   (ks_bit),
    .ks_index (ks_index),
    .dl_ks    (dl_ks),
    .ul_ks    (ul_ks),
    .done     (done)
  );

  always #5 clock = ~clock;

  localparam logic [63:0]  RefKey   = 64'hEFCDAB8967452312;
  localparam logic [21:0]  RefFrame = 22'h134;
  localparam logic [119:0] RefDl    = 120'h534EAA582FE8151AB6E1855A728C00;
  localparam logic [119:0] RefUl    = 120'h24FD35A35D5FB6526D32F906DF1AC0;
`ifdef A5_STALL_EN
  localparam int DoneEdge = 415;  // ready held high: one extra edge to consume index 227
`else
  localparam int DoneEdge = 414;
`endif

  int total = 0;
  int bad   = 0;

  // Observations captured by run_frame
  logic [227:0] got;
  int           got_n, first_valid_e, valid_cycles, done_e, done_n, idx_err, consume_e;
  logic         busy_e1, busy_dn1, busy_dn2;
  logic [113:0] dl_at_done, ul_at_done, dl_late;

  // Bit i of the result is keystream index i.
  function automatic logic [227:0] ref_stream();
    logic [119:0] dh = RefDl;
    logic [119:0] uh = RefUl;
    logic [227:0] s = '0;
    for (int i = 0; i < 114; i++) begin
      s[8'(i)]       = dh[7'(119 - i)];
      s[8'(114 + i)] = uh[7'(119 - i)];
    end
    return s;
  endfunction

  function automatic logic [227:0] a51_model(input logic [63:0] k, input logic [21:0] f);
    logic [18:0]  a = '0;
    logic [21:0]  b = '0;
    logic [22:0]  c = '0;
    logic [227:0] s = '0;
    logic         in_b, m;
    int           votes;
    for (int i = 0; i < 86; i++) begin
      in_b = (i < 64) ? k[6'(i)] : f[5'(i - 64)];
      a = {a[17:0], (^(a & 19'h72000)) ^ in_b};
      b = {b[20:0], (^(b & 22'h300000)) ^ in_b};
      c = {c[21:0], (^(c & 23'h700080)) ^ in_b};
    end
    for (int i = 0; i < 100 + 228; i++) begin
      votes = int'(a[8]) + int'(b[10]) + int'(c[10]);
      m = (votes >= 2);
      if (a[8] == m) a = {a[17:0], ^(a & 19'h72000)};
      if (b[10] == m) b = {b[20:0], ^(b & 22'h300000)};
      if (c[10] == m) c = {c[21:0], ^(c & 23'h700080)};
      if (i >= 100) s[8'(i - 100)] = a[18] ^ b[21] ^ c[22];
    end
    return s;
  endfunction

  task automatic do_reset();
    start = 1'b0;
`ifdef A5_STALL_EN
    ks_ready = 1'b1;
`endif
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Pulse start so that the next rising edge is edge 0, then record everything per cycle.
  task automatic run_frame(input logic [63:0] k, input logic [21:0] f, input bit pulses,
                           input bit rand_ready, input bit restart_idle);
    logic ready_now;
    key = k;
    frame = f;
    got = '0;
    got_n = 0;
    first_valid_e = -1;
    valid_cycles = 0;
    done_e = -1;
    done_n = 0;
    idx_err = 0;
    consume_e = -1;
    busy_e1 = 1'b0;
    busy_dn1 = 1'bx;
    busy_dn2 = 1'bx;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    for (int e = 1; e <= 1500; e++) begin
      @(posedge clock);
      #1;
      start = 1'b0;
      if (e == 1) busy_e1 = busy;
      if (ks_valid) begin
        valid_cycles++;
        if (first_valid_e < 0) first_valid_e = e;
        if (int'(ks_index) != got_n) idx_err++;
      end
      if (done) begin
        done_n++;
        if (done_e < 0) begin
          done_e = e;
          dl_at_done = dl_ks;
          ul_at_done = ul_ks;
        end
      end
      if (done_e >= 0 && e == done_e + 1) busy_dn1 = busy;
      if (done_e >= 0 && e == done_e + 2) begin
        busy_dn2 = busy;
        dl_late = dl_ks;
      end
`ifdef A5_STALL_EN
      ks_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      ready_now = ks_ready;
`else
      ready_now = 1'b1;
`endif
      if (ks_valid && ready_now && got_n < 228) begin
        got[8'(got_n)] = ks_bit;
        got_n++;
`ifdef A5_STALL_EN
        if (got_n == 228) consume_e = e + 1;
`else
        if (got_n == 228) consume_e = e;
`endif
      end
      if (pulses && (e == 49 || e == 199)) start = 1'b1;
      if (pulses && done) start = 1'b1;
      if (restart_idle && done_e >= 0 && e == done_e + 1) start = 1'b1;
      if (done_e >= 0 && e >= done_e + 2) break;
    end
    start = 1'b0;
`ifdef A5_STALL_EN
    ks_ready = 1'b1;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    key = '1;
    frame = '1;
`ifdef A5_STALL_EN
    ks_ready = 1'b1;
`endif
    repeat (3) @(posedge clock);
    #1;
    total++;
    if ({busy, ks_valid, ks_bit, done} !== 4'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 0000", {busy, ks_valid, ks_bit, done});
    end
    total++;
    if (ks_index !== 8'd0) begin
      bad++;
      $display("FAIL reset_index: got %0d want 0", ks_index);
    end
    total++;
    if ({dl_ks, ul_ks} !== '0) begin
      bad++;
      $display("FAIL reset_vectors: got dl=%h ul=%h want 0", dl_ks, ul_ks);
    end
    @(negedge clock);
    reset = 1'b0;
    // start is low, so the block must stay idle.
    repeat (3) @(posedge clock);
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_start: busy got %b want 0", busy);
    end
  endtask

  task automatic test_reference();
    logic [227:0] exp = ref_stream();
    do_reset();
    run_frame(RefKey, RefFrame, 1'b0, 1'b0, 1'b0);
    total++;
    if (busy_e1 !== 1'b1) begin
      bad++;
      $display("FAIL busy_rise: after edge 1 got %b want 1", busy_e1);
    end
    total++;
    if (first_valid_e != 187) begin
      bad++;
      $display("FAIL first_valid: edge got %0d want 187", first_valid_e);
    end
    total++;
    if (valid_cycles != 228) begin
      bad++;
      $display("FAIL valid_cycles: got %0d want 228", valid_cycles);
    end
    total++;
    if (idx_err != 0) begin
      bad++;
      $display("FAIL index_seq: got %0d index errors want 0", idx_err);
    end
    total++;
    if (done_e != DoneEdge || done_n != 1) begin
      bad++;
      $display("FAIL done_timing: edge got %0d (pulses %0d) want %0d (1)", done_e, done_n,
               DoneEdge);
    end
    total++;
    if (done_e != consume_e) begin
      bad++;
      $display("FAIL done_after_last: done edge got %0d want %0d", done_e, consume_e);
    end
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL ref_stream: got %h want %h", got, exp);
    end
    total++;
    if (dl_at_done !== exp[113:0] || ul_at_done !== exp[227:114]) begin
      bad++;
      $display("FAIL ref_parallel: got dl=%h ul=%h want dl=%h ul=%h", dl_at_done, ul_at_done,
               exp[113:0], exp[227:114]);
    end
    total++;
    if (busy_dn1 !== 1'b0) begin
      bad++;
      $display("FAIL busy_fall: after done+1 got %b want 0", busy_dn1);
    end
    total++;
    if (dl_late !== exp[113:0]) begin
      bad++;
      $display("FAIL dl_hold: got %h want %h", dl_late, exp[113:0]);
    end
  endtask

  task automatic test_start_while_busy();
    logic [227:0] exp = ref_stream();
    do_reset();
    run_frame(RefKey, RefFrame, 1'b1, 1'b0, 1'b0);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL busy_restart_stream: got %h want %h", got, exp);
    end
    total++;
    if (done_e != DoneEdge) begin
      bad++;
      $display("FAIL busy_restart_done: edge got %0d want %0d", done_e, DoneEdge);
    end
    total++;
    if (busy_dn1 !== 1'b0 || busy_dn2 !== 1'b0) begin
      bad++;
      $display("FAIL start_in_done: busy got %b%b want 00", busy_dn1, busy_dn2);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_frame(RefKey, RefFrame, 1'b0, 1'b0, 1'b1);
    total++;
    if (busy_dn1 !== 1'b0 || busy_dn2 !== 1'b1) begin
      bad++;
      $display("FAIL idle_restart: busy after done+1/+2 got %b%b want 01", busy_dn1, busy_dn2);
    end
  endtask

  task automatic test_mid_reset();
    logic [227:0] exp = ref_stream();
    bit found = 1'b0;
    do_reset();
    key = RefKey;
    frame = RefFrame;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clock);
      #1;
      if (ks_valid && ks_index == 8'd60) begin
        found = 1'b1;
        break;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL mid_reset_wait: index 60 not seen within 400 cycles");
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({busy, ks_valid, ks_bit, done, ks_index} !== 12'd0) begin
      bad++;
      $display("FAIL mid_reset_ctrl: got %b want 0", {busy, ks_valid, ks_bit, done, ks_index});
    end
    total++;
    if ({dl_ks, ul_ks} !== '0) begin
      bad++;
      $display("FAIL mid_reset_vectors: got dl=%h ul=%h want 0", dl_ks, ul_ks);
    end
    @(negedge clock);
    reset = 1'b0;
    run_frame(RefKey, RefFrame, 1'b0, 1'b0, 1'b0);
    total++;
    if (got !== exp || done_e != DoneEdge) begin
      bad++;
      $display("FAIL post_reset_ref: got %h done %0d want %h done %0d", got, done_e, exp,
               DoneEdge);
    end
  endtask

  task automatic test_all_zero();
    do_reset();
    run_frame(64'd0, 22'd0, 1'b0, 1'b0, 1'b0);
    total++;
    if (got !== '0 || dl_at_done !== '0 || ul_at_done !== '0) begin
      bad++;
      $display("FAIL zero_stream: got %h dl=%h ul=%h want 0", got, dl_at_done, ul_at_done);
    end
    total++;
    if (done_e != DoneEdge || got_n != 228) begin
      bad++;
      $display("FAIL zero_timing: done edge %0d bits %0d want %0d 228", done_e, got_n,
               DoneEdge);
    end
  endtask

  task automatic test_random_keys();
    logic [63:0]  k;
    logic [21:0]  f;
    logic [227:0] exp;
    for (int n = 0; n < 3; n++) begin
      k = {$urandom, $urandom};
      f = 22'($urandom);
      exp = a51_model(k, f);
      do_reset();
      run_frame(k, f, 1'b0, 1'b0, 1'b0);
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL rand_stream[%0d]: key %h frame %h got %h want %h", n, k, f, got, exp);
      end
      total++;
      if (dl_at_done !== exp[113:0] || ul_at_done !== exp[227:114]) begin
        bad++;
        $display("FAIL rand_parallel[%0d]: got dl=%h ul=%h want dl=%h ul=%h", n, dl_at_done,
                 ul_at_done, exp[113:0], exp[227:114]);
      end
    end
  endtask

`ifdef A5_STALL_EN
  task automatic test_stall();
    logic [227:0] exp = ref_stream();
    do_reset();
    run_frame(RefKey, RefFrame, 1'b0, 1'b1, 1'b0);
    total++;
    if (got !== exp || got_n != 228) begin
      bad++;
      $display("FAIL stall_stream: got %h (%0d bits) want %h", got, got_n, exp);
    end
    total++;
    if (idx_err != 0) begin
      bad++;
      $display("FAIL stall_index: got %0d index errors want 0", idx_err);
    end
    total++;
    if (done_e != consume_e || done_n != 1) begin
      bad++;
      $display("FAIL stall_done: edge got %0d want %0d", done_e, consume_e);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_reference();
    test_start_while_busy();
    test_back_to_back();
    test_mid_reset();
    test_all_zero();
    test_random_keys();
`ifdef A5_STALL_EN
    test_stall();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
